// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fullAdder.sv
// Single-bit full-adder cell, purely combinational.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s_c,
    output logic co_c
);

    assign s_c  = a ^ b ^ cin;
    assign co_c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Sequences one fullAdder cell over WIDTH bits, LSB first, and returns
// a registered sum/cout with a one-cycle done pulse.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ps;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             cell_sum;
    logic             cell_cout;
    logic [WIDTH-1:0] ps_next;
    logic             last_bit;

    fullAdder u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .s_c  (cell_sum),
        .co_c (cell_cout)
    );

    // New cell bit enters at the MSB; after WIDTH shifts ps is LSB-aligned.
    generate
        if (WIDTH == 1) begin : g_ps_one
            assign ps_next = cell_sum;
        end else begin : g_ps_wide
            assign ps_next = {cell_sum, ps[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            ps    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= cin;
                        ps    <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    ps    <= ps_next;
                    carry <= cell_cout;
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    cnt   <= CW'(cnt + 1'b1);
                    if (last_bit) begin
                        sum   <= ps_next;
                        cout  <= cell_cout;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized and directed checks of serial_adder_ctrl against a+b+cin.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int checks;
    int errors;

    int         w_cyc;
    int         w_busy;
    bit         w_overlap;
    bit         w_hold_bad;
    bit         w_to;
    logic [7:0] w_prev;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return 9'(x) + 9'(y) + 9'(c);
    endfunction

    // Drive one request; returns just after the accept edge.
    task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic c);
        @(negedge clk);
        a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Observe from just after an accept edge until done, with a cycle bound.
    task automatic wait_done();
        w_cyc = 1; w_busy = 0; w_overlap = 0; w_hold_bad = 0; w_to = 1;
        w_prev = sum;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) w_busy++;
            if (busy && done) w_overlap = 1;
            if (done) begin
                w_to = 0;
                break;
            end
            if (sum !== w_prev) w_hold_bad = 1;
            @(posedge clk);
            w_cyc++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", sum); end
        checks++;
        if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        checks++;
        if (sum4 !== 4'h0 || cout4 !== 1'b0) begin errors++; $display("FAIL reset_w4: got %h/%b expected 0/0", sum4, cout4); end
    endtask

    task automatic test_directed();
        logic [7:0] xa [3];
        logic [7:0] xb [3];
        logic       xc [3];
        logic [8:0] exp;
        xa = '{8'h5A, 8'hFF, 8'hFF};
        xb = '{8'h3C, 8'h01, 8'h00};
        xc = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            start_op(xa[k], xb[k], xc[k]);
            wait_done();
            exp = ref_add8(xa[k], xb[k], xc[k]);
            checks++;
            if (w_to || sum !== exp[7:0] || cout !== exp[8]) begin
                errors++;
                $display("FAIL directed_%0d: got %b/%h expected %b/%h (timeout=%0d)", k, cout, sum, exp[8], exp[7:0], w_to);
            end
            checks++;
            if (w_cyc !== 9) begin errors++; $display("FAIL latency_%0d: got %0d expected 9", k, w_cyc); end
            checks++;
            if (w_busy !== 8) begin errors++; $display("FAIL busy_len_%0d: got %0d expected 8", k, w_busy); end
            checks++;
            if (w_overlap || w_hold_bad) begin errors++; $display("FAIL overlap_hold_%0d: got %b%b expected 00", k, w_overlap, w_hold_bad); end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_random();
        logic [7:0] x, y;
        logic       c;
        logic [8:0] exp;
        for (int k = 0; k < 25; k++) begin
            x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
            start_op(x, y, c);
            wait_done();
            exp = ref_add8(x, y, c);
            checks++;
            if (w_to || sum !== exp[7:0] || cout !== exp[8] || w_cyc !== 9) begin
                errors++;
                $display("FAIL random_%0d: got %b/%h lat %0d expected %b/%h lat 9", k, cout, sum, w_cyc, exp[8], exp[7:0]);
            end
        end
    endtask

    task automatic test_start_in_run();
        logic [8:0] exp;
        bit         extra;
        start_op(8'h37, 8'h4B, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        exp = ref_add8(8'h37, 8'h4B, 1'b1);
        checks++;
        if (w_to || sum !== exp[7:0] || cout !== exp[8]) begin
            errors++;
            $display("FAIL start_in_run: got %b/%h expected %b/%h", cout, sum, exp[8], exp[7:0]);
        end
        checks++;
        if (w_hold_bad) begin errors++; $display("FAIL hold_in_run: got 1 expected 0"); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy || done) extra = 1;
        end
        checks++;
        if (extra) begin errors++; $display("FAIL not_queued: got 1 expected 0"); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp;
        @(negedge clk);
        a = 8'hC3; b = 8'h5E; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 a = 8'h01; b = 8'h02; cin = 1'b0;
        wait_done();
        exp = ref_add8(8'hC3, 8'h5E, 1'b0);
        checks++;
        if (w_to || sum !== exp[7:0] || cout !== exp[8]) begin
            errors++;
            $display("FAIL b2b_first: got %b/%h expected %b/%h", cout, sum, exp[8], exp[7:0]);
        end
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        checks++;
        if (w_to || sum !== 8'h03 || cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got %b/%h expected 0/03", cout, sum);
        end
        checks++;
        if (w_cyc !== 9) begin errors++; $display("FAIL b2b_spacing: got %0d expected 9", w_cyc); end
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        start_op(8'h5A, 8'h3C, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sum !== 8'h00 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got sum %h cout %b busy %b done %b expected all 0", sum, cout, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL reset_discard: got 1 expected 0"); end
        start_op(8'h10, 8'h20, 1'b0);
        wait_done();
        checks++;
        if (w_to || sum !== 8'h30 || cout !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: got %b/%h expected 0/30", cout, sum);
        end
    endtask

    task automatic test_exhaustive_w4();
        logic [4:0] exp;
        bit         to;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); start4 = 1'b1;
                    @(posedge clk);
                    #1 start4 = 1'b0;
                    to = 1;
                    for (int i = 0; i < 20; i++) begin
                        @(negedge clk);
                        if (done4) begin to = 0; break; end
                    end
                    exp = 5'(x + y + c);
                    checks++;
                    if (to || sum4 !== exp[3:0] || cout4 !== exp[4]) begin
                        errors++;
                        $display("FAIL w4_%0d_%0d_%0d: got %b/%h expected %b/%h", x, y, c, cout4, sum4, exp[4], exp[3:0]);
                    end
                end
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        start = 0; a = '0; b = '0; cin = 0;
        start4 = 0; a4 = '0; b4 = '0; cin4 = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive_w4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
